// File: rtl/player_sprite_array_if.sv
// ============================================================================
// player_sprite_array_if : Avalon-MM slave bus for the sprite register file
// Rev 1.0
// ============================================================================
`default_nettype none

interface player_sprite_array_if;
  logic [15:0] writedata;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [4:0]  address;
  logic [15:0] readdata;

  modport master (
    output writedata, write, read, chipselect, address,
    input  readdata
  );

  modport slave (
    input  writedata, write, read, chipselect, address,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/player_sprite_array.sv
// ============================================================================
// player_sprite_array : 640x480 VGA generator with shadowed hardware sprites
// Rev 1.0
// ============================================================================
`default_nettype none

module player_sprite_array #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  player_sprite_array_if.slave avl,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic                 VGA_CLK,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_n,
  output logic                 VGA_SYNC_n
);

  localparam logic [10:0] c_h_last   = 11'd1599;
  localparam logic [10:0] c_h_vis    = 11'd1280;
  localparam logic [10:0] c_hs_lo    = 11'd1312;
  localparam logic [10:0] c_hs_hi    = 11'd1503;
  localparam logic [9:0]  c_v_last   = 10'd524;
  localparam logic [9:0]  c_v_commit = 10'd479;
  localparam logic [9:0]  c_v_vis    = 10'd480;
  localparam logic [9:0]  c_vs_lo    = 10'd490;
  localparam logic [9:0]  c_vs_hi    = 10'd491;
  localparam logic [2:0]  c_num      = 3'(NUM_SPRITES);
  localparam logic [10:0] c_sw       = 11'(SPRITE_W);
  localparam logic [10:0] c_sh       = 11'(SPRITE_H);
  localparam logic [15:0] c_bg_rst   = 16'h0010;
  localparam logic [15:0] c_col_rst  = 16'hFFFF;

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        w_commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (r_hcount == c_h_last) begin
      r_hcount <= '0;
      r_vcount <= (r_vcount == c_v_last) ? '0 : r_vcount + 10'd1;
    end else begin
      r_hcount <= r_hcount + 11'd1;
    end
  end

  assign w_commit = (r_hcount == c_h_last) && (r_vcount == c_v_commit);

  // Bus decode: word blocks of four; block 0 holds BG/CTRL/STATUS, block n>0 is sprite n-1
  logic       w_wr;
  logic       w_status_rd;
  logic [2:0] w_blk;
  logic [2:0] w_idx;
  logic       w_spr_ok;

  assign w_wr        = avl.chipselect && avl.write;
  assign w_status_rd = avl.chipselect && avl.read && (avl.address == 5'd2);
  assign w_blk       = avl.address[4:2];
  assign w_idx       = w_blk - 3'd1;
  assign w_spr_ok    = (w_blk != 3'd0) && (w_idx < c_num);

  logic        r_ctrl;
  logic [15:0] sh_bg, act_bg, nx_bg;
  logic [9:0]  sh_x  [NUM_SPRITES];
  logic [9:0]  sh_y  [NUM_SPRITES];
  logic [15:0] sh_c  [NUM_SPRITES];
  logic        sh_en [NUM_SPRITES];
  logic [9:0]  act_x [NUM_SPRITES];
  logic [9:0]  act_y [NUM_SPRITES];
  logic [15:0] act_c [NUM_SPRITES];
  logic        act_en[NUM_SPRITES];
  logic [9:0]  nx_x  [NUM_SPRITES];
  logic [9:0]  nx_y  [NUM_SPRITES];
  logic [15:0] nx_c  [NUM_SPRITES];
  logic        nx_en [NUM_SPRITES];
  logic        w_load;

  // Shadow always takes every write, so a same-cycle write is already in nx_* at commit
  always_comb begin
    nx_bg = sh_bg;
    if (w_wr && (avl.address == 5'd0))
      nx_bg = avl.writedata;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      nx_x[i]  = sh_x[i];
      nx_y[i]  = sh_y[i];
      nx_c[i]  = sh_c[i];
      nx_en[i] = sh_en[i];
      if (w_wr && w_spr_ok && (w_idx == 3'(i))) begin
        case (avl.address[1:0])
          2'd0:    nx_x[i]  = avl.writedata[9:0];
          2'd1:    nx_y[i]  = avl.writedata[9:0];
          2'd2:    nx_c[i]  = avl.writedata;
          default: nx_en[i] = avl.writedata[0];
        endcase
      end
    end
  end

  assign w_load = !r_ctrl || w_commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= 1'b0;
      sh_bg  <= c_bg_rst;
      act_bg <= c_bg_rst;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        sh_c[i]   <= c_col_rst;
        sh_en[i]  <= 1'b0;
        act_x[i]  <= '0;
        act_y[i]  <= '0;
        act_c[i]  <= c_col_rst;
        act_en[i] <= 1'b0;
      end
    end else begin
      if (w_wr && (avl.address == 5'd1))
        r_ctrl <= avl.writedata[0];
      sh_bg <= nx_bg;
      if (w_load)
        act_bg <= nx_bg;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]  <= nx_x[i];
        sh_y[i]  <= nx_y[i];
        sh_c[i]  <= nx_c[i];
        sh_en[i] <= nx_en[i];
        if (w_load) begin
          act_x[i]  <= nx_x[i];
          act_y[i]  <= nx_y[i];
          act_c[i]  <= nx_c[i];
          act_en[i] <= nx_en[i];
        end
      end
    end
  end

  logic       r_vblank;
  logic [7:0] r_frame;

  // Commit has priority over the read-clear so a pending event is never lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vblank <= 1'b0;
      r_frame  <= '0;
    end else if (w_commit) begin
      r_vblank <= 1'b1;
      r_frame  <= r_frame + 8'd1;
    end else if (w_status_rd) begin
      r_vblank <= 1'b0;
    end
  end

  logic [15:0] w_rdata;
  logic [15:0] r_readdata;

  always_comb begin
    w_rdata = '0;
    case (avl.address)
      5'd0:    w_rdata = sh_bg;
      5'd1:    w_rdata = {15'd0, r_ctrl};
      5'd2:    w_rdata = {r_frame, 7'd0, r_vblank};
      default: begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (w_spr_ok && (w_idx == 3'(i))) begin
            case (avl.address[1:0])
              2'd0:    w_rdata = {6'd0, sh_x[i]};
              2'd1:    w_rdata = {6'd0, sh_y[i]};
              2'd2:    w_rdata = sh_c[i];
              default: w_rdata = {15'd0, sh_en[i]};
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_readdata <= '0;
    else if (avl.chipselect && avl.read)
      r_readdata <= w_rdata;
  end

  assign avl.readdata = r_readdata;

  logic [10:0]            w_col;
  logic [10:0]            w_row;
  logic [NUM_SPRITES-1:0] w_hit;
  logic [15:0]            w_rgb;

  assign w_col = {1'b0, r_hcount[10:1]};
  assign w_row = {1'b0, r_vcount};

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
    assign w_hit[gi] = act_en[gi]
                    && (w_col >= {1'b0, act_x[gi]}) && (w_col < {1'b0, act_x[gi]} + c_sw)
                    && (w_row >= {1'b0, act_y[gi]}) && (w_row < {1'b0, act_y[gi]} + c_sh);
  end

  always_comb begin
    w_rgb = act_bg;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i])
        w_rgb = act_c[i];
    end
  end

  assign VGA_BLANK_n = (r_hcount < c_h_vis) && (r_vcount < c_v_vis);
  assign VGA_R       = VGA_BLANK_n ? {w_rgb[15:11], w_rgb[15:13]} : 8'd0;
  assign VGA_G       = VGA_BLANK_n ? {w_rgb[10:5],  w_rgb[10:9]}  : 8'd0;
  assign VGA_B       = VGA_BLANK_n ? {w_rgb[4:0],   w_rgb[4:2]}   : 8'd0;
  assign VGA_HS      = !((r_hcount >= c_hs_lo) && (r_hcount <= c_hs_hi));
  assign VGA_VS      = !((r_vcount >= c_vs_lo) && (r_vcount <= c_vs_hi));
  assign VGA_CLK     = r_hcount[0];
  assign VGA_SYNC_n  = 1'b0;

endmodule

`default_nettype wire

// File: doc/player_sprite_array.md
PLAYER_SPRITE_ARRAY -- requirements
Module: player_sprite_array

Interface
REQ-001 Parameter NUM_SPRITES, default 4, number of hardware sprites; legal range 1..7.
REQ-002 Parameter SPRITE_W, default 32, sprite width in pixels; legal range 1..64.
REQ-003 Parameter SPRITE_H, default 32, sprite height in pixels; legal range 1..64.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 writedata  input  16  Avalon write data.
REQ-007 write  input  1  Avalon write strobe.
REQ-008 read  input  1  Avalon read strobe.
REQ-009 chipselect  input  1  Avalon select; qualifies read and write.
REQ-010 address  input  5  Avalon word address.
REQ-011 readdata  output  16  Avalon read data.
REQ-012 VGA_R, VGA_G, VGA_B  output  8 each  pixel colour.
REQ-013 VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  output  1 each  VGA timing.

Function
REQ-014 Timing SHALL be 640x480: hcount 0..1599 (pixel col = hcount[10:1]), vcount 0..524; HS low for hcount 1312..1503; VS low for vcount 490..491; BLANK_n high only when hcount<1280 and vcount<480; VGA_CLK = hcount[0]; VGA_SYNC_n = 0.
REQ-015 Register map: 0 BG (RGB565); 1 CTRL (bit0 SHADOW mode); 2 STATUS (read-only); 3 reserved; sprite i at 4+4i: +0 X[9:0], +1 Y[9:0], +2 COLOR RGB565, +3 EN bit0.
REQ-016 Writes to unmapped addresses, STATUS, or sprites >= NUM_SPRITES SHALL be ignored; reads of them SHALL return 0.
REQ-017 With SHADOW=0, a sprite/BG write SHALL update the active register on the next clk edge.
REQ-018 With SHADOW=1, sprite/BG writes SHALL update shadow registers only; CTRL always writes directly.
REQ-019 Commit event = clk with hcount==1599 and vcount==479; with SHADOW=1, all active registers SHALL load from shadow at that edge.
REQ-020 A write coinciding with the commit event SHALL be included in that commit (active takes writedata).
REQ-021 With SHADOW=0, shadow registers SHALL track every write so switching to SHADOW=1 causes no visible change.
REQ-022 Readback SHALL return the shadow copy for sprite/BG addresses, zero-extended.
REQ-023 readdata SHALL be registered: value valid on the clk edge after chipselect&&read; holds otherwise.
REQ-024 STATUS: bit0 VBLANK_PEND, bits[15:8] FRAME_CNT, others 0.
REQ-025 VBLANK_PEND SHALL set at the commit event and clear on a STATUS read; simultaneous set and clear -> set wins.
REQ-026 FRAME_CNT SHALL increment at each commit event, wrapping 255->0.
REQ-027 Sprite i hit: EN=1 and X<=col<X+SPRITE_W and Y<=row<Y+SPRITE_H, compared at 11-bit width (no wrap; right/bottom overflow clipped).
REQ-028 Colour: BLANK_n=0 -> 0; else lowest-index hit sprite COLOR; else BG. RGB565 expands by bit replication (R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}).
REQ-029 Colour output SHALL be combinational from current counters and active registers (zero latency).

Reset
REQ-030 Reset SHALL force hcount=vcount=0, CTRL=0, BG=0x0010, all X=Y=0, COLOR=0xFFFF, EN=0, VBLANK_PEND=0, FRAME_CNT=0, readdata=0, in both shadow and active copies.
REQ-031 Reset asserted mid-frame SHALL restart timing at hcount=vcount=0 and discard uncommitted shadow writes.

Verification
REQ-032 After reset, pixel (0,0) -> RGB (0x00,0x00,0x84); readback of sprite 0 COLOR -> 0xFFFF.
REQ-033 SHADOW=0; sprite0 X=100,Y=50,COLOR=0xF800,EN=1 -> pixels (100..131,50..81) = (0xFF,0,0), (132,50) = BG.
REQ-034 Sprites 0 and 1 overlap at (200,200), colours 0x07E0/0x001F -> overlap shows (0,0xFF,0).
REQ-035 SHADOW=1; write sprite0 X=300 mid-frame -> old position until vcount 480, new position next frame; write at commit cycle itself lands.
REQ-036 Read STATUS after two commits -> 0x0201, next read -> 0x0200; read on commit cycle -> bit0 stays 1.
REQ-037 Sprite X=620 -> visible cols 620..639 only, no wrap to col 0; write to address 4+4*NUM_SPRITES -> no effect, reads 0.
